aes_round_ctrl: RTL and testbench
=================================

// Module: aes_round_ctrl
// PURPOSE
//  Iterative AES encryption sequencer. Owns the 128-bit cipher state register and the round counter.
//  Each cycle it drives one round through the shared combinational round datapath
//  (SubBytes/ShiftRows/MixColumns/AddRoundKey built around aes_mix) and the key-schedule lookup.
//  Sits between the block-level valid/ready stream interface and the round datapath.
//  One block is in flight at a time.
// PARAMETERS
//  NR   10   number of rounds; legal values 10/12/14 (AES-128/192/256); any other value is a $fatal at elaboration
// PORTS
//  clk          in   1    sole clock, rising edge
//  rst_n        in   1    asynchronous active-low reset
//  in_valid     in   1    plaintext block offered
//  in_ready     out  1    controller accepts block this cycle
//  in_data      in   128  plaintext; byte 15 = [127:120] = first FIPS byte
//  out_valid    out  1    ciphertext available
//  out_ready    in   1    downstream accepts ciphertext
//  out_data     out  128  ciphertext; same byte order as in_data
//  rnd_idx      out  4    round index to key schedule; rkey must equal round key rnd_idx, same cycle
//  rkey         in   128  round key for rnd_idx, combinational
//  rnd_state    out  128  current state register, fed to the round datapath
//  rnd_last     out  1    final round: datapath must bypass MixColumns
//  rnd_result   in   128  round datapath output for rnd_state/rkey/rnd_last, combinational
//  busy         out  1    block in flight (state ROUND or DONE)
// BEHAVIOUR
//  Reset values: in_ready=0, out_valid=0, busy=0, rnd_idx=0, rnd_last=0, state register=0, FSM=IDLE.
//  in_ready rises the first cycle after reset release.
//  FSM states:
//   - IDLE:  in_ready=1, rnd_idx=0.
//            On in_valid&in_ready: state <= in_data ^ rkey (initial AddRoundKey); rnd_idx <= 1; go ROUND.
//   - ROUND: in_ready=0. Each cycle: state <= rnd_result; rnd_last = (rnd_idx==NR).
//            If rnd_idx<NR: rnd_idx++. If rnd_idx==NR: rnd_idx <= 0; go DONE.
//   - DONE:  out_valid=1; out_data=state register, held stable until out_ready.
//            On out_ready:
//              - in_valid=1: same cycle captures the next block exactly as in IDLE; go ROUND.
//              - otherwise: go IDLE.
//  in_ready = IDLE | (DONE & out_ready). This is the only combinational path from out_ready to in_ready.
//  Latency: handshake at cycle 0 -> out_valid at cycle NR+1.
//  Throughput: 1 block per NR+1 cycles with out_ready held high.
//  rnd_idx never exceeds NR.
//  rnd_last is 1 only in ROUND with rnd_idx==NR.
//  rnd_last is registered-state decode only: no input-to-output path.
//  Input values are ignored unless a handshake occurs. in_valid may drop at any time without effect.
//  out_valid, once high, stays high and out_data stays constant until out_ready (no retraction).
//  Reset asserted mid-block: aborts immediately to the reset values. No partial output is ever produced.
//  X on rnd_result outside ROUND must not propagate into the state register.
// CONFIGURATION
//  AES_PERF_CNT_EN defined:
//   - adds output perf_blocks [31:0], reset 0.
//   - +1 on every out_valid&out_ready; wraps 0xFFFFFFFF->0.
//   - adds output perf_stall [31:0], reset 0.
//   - +1 every cycle in DONE with out_ready=0; wraps.
//  Undefined: neither port exists and no counter logic is synthesised; all other behaviour is identical.
// TESTING
//  Bench supplies a golden round datapath and key schedule; NR=10 for all cases unless noted.
//  1 FIPS-197 App.B: key 2b7e151628aed2a6abf7158809cf4f3c, pt 3243f6a8885a308d313198a2e0370734
//    -> out_data 3925841d02dc09fbdc118597196a0b32, out_valid at cycle 11 after handshake.
//  2 Back-to-back: out_ready=1, in_valid=1 with two blocks -> second handshake in the same cycle as the first
//    out handshake; outputs 11 cycles apart; rnd_last pulses once per block at rnd_idx=10.
//  3 Backpressure: out_ready=0 for 20 cycles in DONE -> out_data stable, in_ready=0, busy=1;
//    release -> one transfer, then IDLE.
//  4 rst_n pulsed low during ROUND at rnd_idx=5 -> outputs immediately at reset values, no out_valid;
//    next block encrypts correctly.
//  5 NR=14, FIPS-197 C.3: key 000102..1f, pt 00112233445566778899aabbccddeeff
//    -> 8ea2b7ca516745bfeafc49904b496089 at cycle 15.
//  6 AES_PERF_CNT_EN: 3 blocks, each stalled 4 cycles -> perf_blocks=3, perf_stall=12;
//    preload perf_blocks to 0xFFFFFFFF via force -> wraps to 0.

Source files
------------

// File: rtl/aes_round_ctrl.sv
// aes_round_ctrl - iterative AES encryption sequencer.
//
// Owns the 128-bit cipher state register and the round counter. It runs one
// round per cycle through an external combinational round datapath and
// key-schedule lookup. Only one block is in flight at a time.
//
// Parameters:
//   NR          number of rounds: 10, 12 or 14 (AES-128/192/256)
//
// Ports:
//   clk         sole clock, rising edge
//   rst_n       asynchronous active-low reset
//   in_valid    plaintext block offered
//   in_ready    block accepted this cycle
//   in_data     plaintext; [127:120] is the first FIPS byte
//   out_valid   ciphertext available
//   out_ready   downstream accepts ciphertext
//   out_data    ciphertext, same byte order as in_data
//   rnd_idx     round index presented to the key schedule
//   rkey        round key for rnd_idx, combinational
//   rnd_state   current state register, fed to the round datapath
//   rnd_last    final round: the datapath bypasses MixColumns
//   rnd_result  round datapath output, combinational
//   busy        block in flight (ROUND or DONE)
//
// Build option:
//   AES_PERF_CNT_EN  adds perf_blocks (completed transfers) and perf_stall
//                    (cycles in DONE while out_ready is low), both 32-bit
//                    wrapping counters.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | waiting for a block; in_ready high once out of reset
// S_ROUND | one round per cycle, rnd_idx = 1..NR
// S_DONE  | ciphertext held on out_data until out_ready

module aes_round_ctrl #(
   parameter int NR = 10
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [127:0] in_data,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [127:0] out_data,
   output logic [3:0]   rnd_idx,
   input  logic [127:0] rkey,
   output logic [127:0] rnd_state,
   output logic         rnd_last,
   input  logic [127:0] rnd_result,
   output logic         busy
`ifdef AES_PERF_CNT_EN
   ,
   output logic [31:0]  perf_blocks,
   output logic [31:0]  perf_stall
`endif
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ROUND = 2'd1,
      S_DONE  = 2'd2
   } state_e;

   localparam logic [3:0] NR_L = 4'(NR);

   generate
      if (NR != 10 && NR != 12 && NR != 14) begin : g_bad_nr
         $fatal(1, "aes_round_ctrl: NR must be 10, 12 or 14");
      end
   endgenerate

   state_e       fsm_q;
   logic [127:0] state_q;
   logic [127:0] state_d;
   logic [3:0]   rnd_idx_q;
   logic         rnd_last_q;
   logic         out_valid_q;
   logic         busy_q;
   logic         armed_q;
   logic         accept;

   // armed_q holds in_ready low for the reset cycle itself; it rises on the
   // first clock after reset release. out_ready -> in_ready through DONE is
   // the only combinational input-to-output path.
   assign in_ready = ((fsm_q == S_IDLE) & armed_q) | ((fsm_q == S_DONE) & out_ready);
   assign accept   = in_valid & in_ready;

   // Initial AddRoundKey. rnd_idx is 0 in both IDLE and DONE, so rkey is
   // round key 0 whenever a capture can happen.
   assign state_d  = in_data ^ rkey;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fsm_q       <= S_IDLE;
         state_q     <= '0;
         rnd_idx_q   <= '0;
         rnd_last_q  <= 1'b0;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
         armed_q     <= 1'b0;
      end else begin
         armed_q <= 1'b1;
         case (fsm_q)
            S_IDLE: begin
               if (accept) begin
                  state_q    <= state_d;
                  rnd_idx_q  <= 4'd1;
                  rnd_last_q <= 1'b0;
                  busy_q     <= 1'b1;
                  fsm_q      <= S_ROUND;
               end
            end
            S_ROUND: begin
               // rnd_result is only sampled here, so X from an idle datapath
               // never reaches the state register.
               state_q <= rnd_result;
               if (rnd_idx_q == NR_L) begin
                  rnd_idx_q   <= 4'd0;
                  rnd_last_q  <= 1'b0;
                  out_valid_q <= 1'b1;
                  fsm_q       <= S_DONE;
               end else begin
                  rnd_idx_q  <= rnd_idx_q + 4'd1;
                  rnd_last_q <= ((rnd_idx_q + 4'd1) == NR_L);
               end
            end
            S_DONE: begin
               if (out_ready) begin
                  out_valid_q <= 1'b0;
                  if (in_valid) begin
                     state_q    <= state_d;
                     rnd_idx_q  <= 4'd1;
                     rnd_last_q <= 1'b0;
                     fsm_q      <= S_ROUND;
                  end else begin
                     busy_q <= 1'b0;
                     fsm_q  <= S_IDLE;
                  end
               end
            end
            default: begin
               out_valid_q <= 1'b0;
               busy_q      <= 1'b0;
               rnd_idx_q   <= 4'd0;
               rnd_last_q  <= 1'b0;
               fsm_q       <= S_IDLE;
            end
         endcase
      end
   end

   assign out_valid = out_valid_q;
   assign out_data  = state_q;
   assign rnd_state = state_q;
   assign rnd_idx   = rnd_idx_q;
   assign rnd_last  = rnd_last_q;
   assign busy      = busy_q;

`ifdef AES_PERF_CNT_EN
   logic [31:0] perf_blocks_q;
   logic [31:0] perf_stall_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         perf_blocks_q <= '0;
         perf_stall_q  <= '0;
      end else begin
         if (out_valid_q && out_ready) begin
            perf_blocks_q <= perf_blocks_q + 32'd1;
         end
         if ((fsm_q == S_DONE) && !out_ready) begin
            perf_stall_q <= perf_stall_q + 32'd1;
         end
      end
   end

   assign perf_blocks = perf_blocks_q;
   assign perf_stall  = perf_stall_q;
`endif

endmodule

// File: tb/tb_aes_round_ctrl.sv
// tb_aes_round_ctrl - directed bench for aes_round_ctrl. Provides a golden
// AES round datapath and key schedule around an NR=10 and an NR=14 instance.
// Define AES_PERF_CNT_EN to exercise the performance counters.

module tb_aes_round_ctrl;

   localparam logic [127:0] PT_B = 128'h3243f6a8885a308d313198a2e0370734;
   localparam logic [127:0] CT_B = 128'h3925841d02dc09fbdc118597196a0b32;
   localparam logic [127:0] PT_C = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] CT_C3 = 128'h8ea2b7ca516745bfeafc49904b496089;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic         in_valid, in_ready, out_valid, out_ready, rnd_last, busy;
   logic [127:0] in_data, out_data, rkey, rnd_state, rnd_result;
   logic [3:0]   rnd_idx;

   logic         v14, r14, ov14, or14, last14, busy14;
   logic [127:0] d14, od14, rkey14, st14, res14;
   logic [3:0]   idx14;
`ifdef AES_PERF_CNT_EN
   logic [31:0]  perf_blocks, perf_stall, pb14, ps14;
`endif

   logic [7:0]   sbox_t [0:255];
   logic [127:0] rk10 [0:14];
   logic [127:0] rk14 [0:14];
   logic         tbl_ok = 1'b0;

   int n_chk = 0;
   int n_fail = 0;
   int last_cnt, last_bad, max_idx, hold_bad;

   aes_round_ctrl #(.NR(10)) u_dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .rnd_idx(rnd_idx), .rkey(rkey), .rnd_state(rnd_state),
      .rnd_last(rnd_last), .rnd_result(rnd_result), .busy(busy)
`ifdef AES_PERF_CNT_EN
      , .perf_blocks(perf_blocks), .perf_stall(perf_stall)
`endif
   );

   aes_round_ctrl #(.NR(14)) u_dut14 (
      .clk(clk), .rst_n(rst_n),
      .in_valid(v14), .in_ready(r14), .in_data(d14),
      .out_valid(ov14), .out_ready(or14), .out_data(od14),
      .rnd_idx(idx14), .rkey(rkey14), .rnd_state(st14),
      .rnd_last(last14), .rnd_result(res14), .busy(busy14)
`ifdef AES_PERF_CNT_EN
      , .perf_blocks(pb14), .perf_stall(ps14)
`endif
   );

   function automatic logic [7:0] xt(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] x;
      p = 8'h00;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p ^= x;
         x = xt(x);
      end
      return p;
   endfunction

   function automatic logic [31:0] subw(input logic [31:0] t);
      return {sbox_t[t[31:24]], sbox_t[t[23:16]], sbox_t[t[15:8]], sbox_t[t[7:0]]};
   endfunction

   // Byte i (FIPS order) sits at [127-8i -: 8]; column c holds bytes 4c..4c+3.
   function automatic logic [127:0] aes_round(input logic [127:0] s, input logic [127:0] k_in,
                                              input logic last);
      logic [7:0]   b [0:15];
      logic [7:0]   t [0:15];
      logic [7:0]   a0, a1, a2, a3;
      logic [127:0] r;
      for (int i = 0; i < 16; i++) b[i] = sbox_t[s[127-8*i -: 8]];
      for (int c = 0; c < 4; c++)
         for (int rw = 0; rw < 4; rw++) t[rw+4*c] = b[rw+4*((c+rw)%4)];
      if (!last) begin
         for (int c = 0; c < 4; c++) begin
            a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
            t[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
            t[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
            t[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
            t[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
         end
      end
      for (int i = 0; i < 16; i++) r[127-8*i -: 8] = t[i];
      return r ^ k_in;
   endfunction

   function automatic logic [127:0] ref_encrypt(input logic [127:0] pt, input bit use14);
      logic [127:0] s;
      int nr;
      nr = use14 ? 14 : 10;
      s  = pt ^ (use14 ? rk14[0] : rk10[0]);
      for (int r = 1; r <= nr; r++) s = aes_round(s, use14 ? rk14[r] : rk10[r], r == nr);
      return s;
   endfunction

   task automatic build_sbox();
      logic [7:0] inv;
      logic [7:0] a8;
      for (int a = 0; a < 256; a++) begin
         a8  = 8'(a);
         inv = 8'h00;
         if (a != 0)
            for (int b = 1; b < 256; b++) if (gmul(a8, 8'(b)) == 8'h01) inv = 8'(b);
         sbox_t[a] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
                     {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
      end
   endtask

   task automatic key_expand(input logic [255:0] key, input int nk, input bit to14);
      logic [31:0] w [0:59];
      logic [31:0] t;
      logic [7:0]  rc;
      int nr;
      nr = nk + 6;
      rc = 8'h01;
      for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
      for (int i = nk; i < 4*(nr+1); i++) begin
         t = w[i-1];
         if (i % nk == 0) begin
            t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
            rc = xt(rc);
         end else if (nk > 6 && i % nk == 4) begin
            t = subw(t);
         end
         w[i] = w[i-nk] ^ t;
      end
      for (int r = 0; r <= nr; r++) begin
         if (to14) rk14[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
         else      rk10[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
      end
   endtask

   // Golden datapath and key schedule; tbl_ok keeps the lookups re-evaluated
   // once the tables have been built.
   assign rkey       = tbl_ok ? rk10[rnd_idx] : '0;
   assign rnd_result = aes_round(rnd_state, rkey, rnd_last);
   assign rkey14     = tbl_ok ? rk14[idx14] : '0;
   assign res14      = aes_round(st14, rkey14, last14);

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Offers pt from a negedge in IDLE, keeps in_valid high with junk data
   // while rounds run, then holds the result for 'stall' cycles before
   // taking it. Leaves the bench at the negedge after the output transfer.
   task automatic run_block(input logic [127:0] pt, input int stall,
                            output int lat, output logic [127:0] ct);
      int w;
      w = 0;
      while (!in_ready && w < 30) begin
         @(negedge clk);
         w++;
      end
      if (!in_ready) chk("in_ready_wait", {127'd0, in_ready}, 128'd1);
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_data   = pt;
      lat = 0; last_cnt = 0; last_bad = 0; max_idx = 0; hold_bad = 0;
      do begin
         @(negedge clk);
         lat++;
         in_data = {$urandom, $urandom, $urandom, $urandom};
         if (rnd_last) last_cnt++;
         if (rnd_last && rnd_idx != 4'd10) last_bad++;
         if (int'(rnd_idx) > max_idx) max_idx = int'(rnd_idx);
      end while (!out_valid && lat < 40);
      if (!out_valid) chk("out_valid_wait", {127'd0, out_valid}, 128'd1);
      ct = out_data;
      for (int i = 0; i < stall; i++) begin
         @(negedge clk);
         if (out_data !== ct || in_ready !== 1'b0 || busy !== 1'b1 || out_valid !== 1'b1)
            hold_bad++;
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat, c, hs_n, out_n, lc;
      int hs_c [0:1];
      int out_c [0:1];
      logic [127:0] out_d [0:1];
      logic [127:0] ct;
      logic hs, ot;

      in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
      v14 = 1'b0; d14 = '0; or14 = 1'b0;
      build_sbox();
      key_expand({128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0}, 4, 1'b0);
      key_expand(256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f, 8, 1'b1);
      tbl_ok = 1'b1;
      chk("ref_model_fips_b", ref_encrypt(PT_B, 1'b0), CT_B);

      // Reset values
      repeat (3) @(negedge clk);
      chk("rst_in_ready", {127'd0, in_ready}, 128'd0);
      chk("rst_out_valid", {127'd0, out_valid}, 128'd0);
      chk("rst_busy", {127'd0, busy}, 128'd0);
      chk("rst_rnd_idx", {124'd0, rnd_idx}, 128'd0);
      chk("rst_rnd_last", {127'd0, rnd_last}, 128'd0);
      chk("rst_state", rnd_state, 128'd0);
      rst_n = 1'b1;
      #1 chk("rel_in_ready_low", {127'd0, in_ready}, 128'd0);
      @(negedge clk);
      chk("rel_in_ready_high", {127'd0, in_ready}, 128'd1);

      // FIPS-197 App. B
      run_block(PT_B, 0, lat, ct);
      chk("b_latency", 128'(lat), 128'd11);
      chk("b_ct", ct, CT_B);
      chk("b_last_count", 128'(last_cnt), 128'd1);
      chk("b_last_wrong_idx", 128'(last_bad), 128'd0);
      chk("b_max_idx", 128'(max_idx), 128'd10);
      chk("b_post_out_valid", {127'd0, out_valid}, 128'd0);
      chk("b_post_busy", {127'd0, busy}, 128'd0);
      chk("b_post_in_ready", {127'd0, in_ready}, 128'd1);

      // Back-to-back with out_ready held high
      out_ready = 1'b1; in_valid = 1'b1; in_data = PT_B;
      hs_n = 0; out_n = 0; lc = 0;
      hs_c[0] = -1; hs_c[1] = -1; out_c[0] = -1; out_c[1] = -1;
      out_d[0] = '0; out_d[1] = '0;
      for (c = 0; c < 40; c++) begin
         hs = in_valid & in_ready;
         ot = out_valid & out_ready;
         if (ot && out_n < 2) begin out_c[out_n] = c; out_d[out_n] = out_data; out_n++; end
         if (hs && hs_n < 2) begin hs_c[hs_n] = c; hs_n++; end
         if (rnd_last) lc++;
         @(negedge clk);
         if (hs) begin
            if (hs_n == 1) in_data = PT_C;
            else in_valid = 1'b0;
         end
         if (out_n == 2) break;
      end
      out_ready = 1'b0;
      chk("b2b_hs1_cycle", 128'(hs_c[0]), 128'd0);
      chk("b2b_out1_cycle", 128'(out_c[0]), 128'd11);
      chk("b2b_hs2_cycle", 128'(hs_c[1]), 128'd11);
      chk("b2b_out2_cycle", 128'(out_c[1]), 128'd22);
      chk("b2b_ct1", out_d[0], CT_B);
      chk("b2b_ct2", out_d[1], ref_encrypt(PT_C, 1'b0));
      chk("b2b_last_count", 128'(lc), 128'd2);

      // Backpressure: 20 cycles stalled in DONE
      run_block(PT_C, 20, lat, ct);
      chk("bp_hold", 128'(hold_bad), 128'd0);
      chk("bp_ct", ct, ref_encrypt(PT_C, 1'b0));
      chk("bp_post_in_ready", {127'd0, in_ready}, 128'd1);
      chk("bp_post_busy", {127'd0, busy}, 128'd0);
      @(negedge clk);
      chk("bp_single_transfer", {127'd0, out_valid}, 128'd0);

      // Reset mid-block at rnd_idx 5
      in_valid = 1'b1; in_data = PT_B; c = 0;
      @(negedge clk);
      in_valid = 1'b0;
      while (rnd_idx != 4'd5 && c < 20) begin @(negedge clk); c++; end
      chk("mid_reached_idx5", {124'd0, rnd_idx}, 128'd5);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_out_valid", {127'd0, out_valid}, 128'd0);
      chk("mid_rst_busy", {127'd0, busy}, 128'd0);
      chk("mid_rst_in_ready", {127'd0, in_ready}, 128'd0);
      chk("mid_rst_rnd_idx", {124'd0, rnd_idx}, 128'd0);
      chk("mid_rst_state", rnd_state, 128'd0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      out_ready = 1'b1; lc = 0;
      repeat (15) begin @(negedge clk); if (out_valid || busy) lc++; end
      out_ready = 1'b0;
      chk("mid_no_output", 128'(lc), 128'd0);
      run_block(PT_B, 0, lat, ct);
      chk("mid_next_ct", ct, CT_B);
      chk("mid_next_latency", 128'(lat), 128'd11);

      // NR=14, FIPS-197 C.3
      v14 = 1'b1; d14 = PT_C; lat = 0;
      chk("nr14_in_ready", {127'd0, r14}, 128'd1);
      @(negedge clk);
      v14 = 1'b0; d14 = '0;
      lat = 1;
      while (!ov14 && lat < 40) begin @(negedge clk); lat++; end
      chk("nr14_latency", 128'(lat), 128'd15);
      chk("nr14_ct", od14, CT_C3);
      or14 = 1'b1;
      @(negedge clk);
      or14 = 1'b0;
      chk("nr14_post_busy", {127'd0, busy14}, 128'd0);

`ifdef AES_PERF_CNT_EN
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      repeat (3) run_block(PT_B, 4, lat, ct);
      chk("perf_blocks_3", {96'd0, perf_blocks}, 128'd3);
      chk("perf_stall_12", {96'd0, perf_stall}, 128'd12);
      force u_dut.perf_blocks_q = 32'hffff_ffff;
      #1 release u_dut.perf_blocks_q;
      run_block(PT_B, 0, lat, ct);
      chk("perf_blocks_wrap", {96'd0, perf_blocks}, 128'd0);
      chk("perf_stall_kept", {96'd0, perf_stall}, 128'd12);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
